// File: rtl/arb_rr_4x2.sv
// Four-requester round-robin arbiter with a per-grant hold limit.
// A grant is registered one cycle after the request. Any grant is followed by
// at least one IDLE cycle. The priority pointer moves past the grantee only
// on a normal or timed-out release, never on reset.
//
// state | meaning
// IDLE  | no grant active; arbitrate among req from ptr upward
// BUSY  | one requester holds the resource; watch done, req drop, hold limit
module arb_rr_4x2 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     r_state,     w_state_nxt;
  logic [1:0] r_ptr,       w_ptr_nxt;
  logic [7:0] r_hold_cnt,  w_hold_cnt_nxt;
  logic [3:0] r_gnt,       w_gnt_nxt;
  logic [1:0] r_gnt_id,    w_gnt_id_nxt;
  logic       r_gnt_valid, w_gnt_valid_nxt;
  logic       r_timeout,   w_timeout_nxt;

  logic [7:0] w_hold_last;
  logic [1:0] w_win_id;
  logic       w_win_found;
  logic       w_rel_done;
  logic       w_rel_drop;
  logic       w_rel_limit;
  logic       w_release;

  assign w_hold_last = 8'(MAX_HOLD - 1);

  // Round-robin winner: walk offsets from the top down so the smallest
  // offset from ptr is the last (and therefore winning) assignment.
  always_comb begin
    logic [1:0] cand;
    w_win_found = 1'b0;
    w_win_id    = r_ptr;
    cand        = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = r_ptr + 2'(k);
      if (req[cand]) begin
        w_win_found = 1'b1;
        w_win_id    = cand;
      end
    end
  end

  // Release causes; timeout only when the hold limit is the sole cause.
  always_comb begin
    w_rel_done  = done;
    w_rel_drop  = ~req[r_gnt_id];
    w_rel_limit = (r_hold_cnt == w_hold_last);
    w_release   = (r_state == BUSY) && (w_rel_done || w_rel_drop || w_rel_limit);
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_gnt_nxt       = r_gnt;
    w_gnt_id_nxt    = r_gnt_id;
    w_gnt_valid_nxt = r_gnt_valid;
    w_timeout_nxt   = 1'b0;

    case (r_state)
      IDLE: begin
        w_hold_cnt_nxt  = 8'd0;
        w_gnt_nxt       = 4'b0000;
        w_gnt_id_nxt    = 2'b00;
        w_gnt_valid_nxt = 1'b0;
        if (w_win_found) begin
          w_state_nxt     = BUSY;
          w_gnt_nxt       = 4'(4'b0001 << w_win_id);
          w_gnt_id_nxt    = w_win_id;
          w_gnt_valid_nxt = 1'b1;
        end
      end
      BUSY: begin
        if (w_release) begin
          w_state_nxt     = IDLE;
          w_ptr_nxt       = r_gnt_id + 2'd1;
          w_hold_cnt_nxt  = 8'd0;
          w_gnt_nxt       = 4'b0000;
          w_gnt_id_nxt    = 2'b00;
          w_gnt_valid_nxt = 1'b0;
          w_timeout_nxt   = w_rel_limit && !w_rel_done && !w_rel_drop;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_hold_cnt_nxt  = 8'd0;
        w_gnt_nxt       = 4'b0000;
        w_gnt_id_nxt    = 2'b00;
        w_gnt_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= 2'd0;
      r_hold_cnt  <= 8'd0;
      r_gnt       <= 4'b0000;
      r_gnt_id    <= 2'b00;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule
